// File: rtl/rx_reset_sequencer_pkg.sv
// Shared definitions for the receiver reset sequencer: FSM state encoding,
// consecutive-reset counter width and a saturating increment helper.
package rx_reset_sequencer_pkg;

    localparam int CONSEC_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESET   = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_LOCKOUT = 2'd3
    } seq_state_t;

    function automatic logic [CONSEC_W-1:0] consec_inc(input logic [CONSEC_W-1:0] v);
        return (v == '1) ? v : v + CONSEC_W'(1);
    endfunction

endpackage

// File: rtl/rx_reset_sequencer_timer.sv
// Loadable down-counter shared by the RESET and HOLDOFF phases.
// Priority: clear, then load, then decrement; o_zero reflects the stored value.
module rx_reset_sequencer_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/rx_reset_sequencer.sv
// Turns watchdog reset requests into fixed-length rx resets, blanks the watchdog
// afterwards, counts resets and locks out after repeated resets without a SIGNAL.
module rx_reset_sequencer
    import rx_reset_sequencer_pkg::*;
#(
    parameter int HOLD_WIDTH    = 8,
    parameter int HOLDOFF_WIDTH = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     enable,
    input  logic                     wd_rst_req,
    input  logic                     power_trigger,
    input  logic                     sig_valid,
    input  logic [HOLD_WIDTH-1:0]    rst_hold_len,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff_len,
    input  logic [3:0]               max_consec_th,
    input  logic                     cnt_clr,
    output logic                     rx_rst,
    output logic                     wd_enable,
    output logic [CNT_WIDTH-1:0]     rst_count,
    output logic                     locked_out
);

    seq_state_t          r_state;
    seq_state_t          w_state_next;
    logic [CONSEC_W-1:0] r_consec;
    logic [CONSEC_W-1:0] w_consec_next;
    logic [3:0]          r_consec_th;
    logic                r_pt_prev;
    logic                r_rx_rst;
    logic                r_wd_enable;
    logic                r_locked_out;
    logic [CNT_WIDTH-1:0] r_rst_count;
    logic [CNT_WIDTH-1:0] w_rst_count_next;

    logic                     w_start;
    logic                     w_lock_release;
    logic                     w_pt_fall;
    logic                     w_tmr_clr;
    logic                     w_tmr_load;
    logic                     w_tmr_dec;
    logic                     w_tmr_zero;
    logic [HOLDOFF_WIDTH-1:0] w_tmr_load_val;
    logic [HOLDOFF_WIDTH-1:0] w_hold_m1;
    logic [HOLDOFF_WIDTH-1:0] w_holdoff_m1;

    // Timer holds (cycles remaining - 1); a phase ends in the cycle it reads zero.
    assign w_hold_m1    = (rst_hold_len == '0) ? '0
                        : (HOLDOFF_WIDTH'(rst_hold_len) - HOLDOFF_WIDTH'(1));
    assign w_holdoff_m1 = holdoff_len - HOLDOFF_WIDTH'(1);
    assign w_pt_fall    = r_pt_prev & ~power_trigger;

    rx_reset_sequencer_timer #(
        .WIDTH (HOLDOFF_WIDTH)
    ) u_timer (
        .clk        (clk),
        .rstn       (rstn),
        .i_clr      (w_tmr_clr),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_load_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_start        = 1'b0;
        w_lock_release = 1'b0;
        w_tmr_clr      = 1'b0;
        w_tmr_load     = 1'b0;
        w_tmr_load_val = '0;
        w_tmr_dec      = 1'b0;
        if (!enable) begin
            w_state_next = ST_IDLE;
            w_tmr_clr    = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (wd_rst_req) begin
                        w_state_next   = ST_RESET;
                        w_start        = 1'b1;
                        w_tmr_load     = 1'b1;
                        w_tmr_load_val = w_hold_m1;
                    end
                end
                ST_RESET: begin
                    if (!w_tmr_zero) begin
                        w_tmr_dec = 1'b1;
                    end else if ((r_consec_th != 4'd0) && (r_consec >= r_consec_th)) begin
                        w_state_next = ST_LOCKOUT;
                    end else if (holdoff_len == '0) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next   = ST_HOLDOFF;
                        w_tmr_load     = 1'b1;
                        w_tmr_load_val = w_holdoff_m1;
                    end
                end
                ST_HOLDOFF: begin
                    if (!w_tmr_zero) begin
                        w_tmr_dec = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_LOCKOUT: begin
                    if (w_pt_fall) begin
                        w_state_next   = ST_IDLE;
                        w_lock_release = 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // A SIGNAL seen in the same cycle as a new reset still counts that reset.
    always_comb begin
        w_consec_next = r_consec;
        if (w_start) begin
            w_consec_next = sig_valid ? CONSEC_W'(1) : consec_inc(r_consec);
        end else if (sig_valid || w_lock_release) begin
            w_consec_next = '0;
        end
    end

    always_comb begin
        w_rst_count_next = r_rst_count;
        if (cnt_clr) begin
            w_rst_count_next = w_start ? CNT_WIDTH'(1) : '0;
        end else if (w_start && (r_rst_count != '1)) begin
            w_rst_count_next = r_rst_count + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_consec     <= '0;
            r_consec_th  <= '0;
            r_pt_prev    <= 1'b0;
            r_rx_rst     <= 1'b0;
            r_wd_enable  <= 1'b0;
            r_locked_out <= 1'b0;
            r_rst_count  <= '0;
        end else begin
            r_consec     <= w_consec_next;
            r_pt_prev    <= power_trigger;
            r_rx_rst     <= (w_state_next == ST_RESET);
            r_wd_enable  <= (w_state_next == ST_IDLE) && enable;
            r_locked_out <= (w_state_next == ST_LOCKOUT);
            r_rst_count  <= w_rst_count_next;
            if (w_start) begin
                r_consec_th <= max_consec_th;
            end
        end
    end

    assign rx_rst     = r_rx_rst;
    assign wd_enable  = r_wd_enable;
    assign rst_count  = r_rst_count;
    assign locked_out = r_locked_out;

endmodule

// File: tb/tb_rx_reset_sequencer.sv
// Directed bench for rx_reset_sequencer (4-bit statistics counter build).
module tb_rx_reset_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic        wd_rst_req;
    logic        power_trigger;
    logic        sig_valid;
    logic [7:0]  rst_hold_len;
    logic [15:0] holdoff_len;
    logic [3:0]  max_consec_th;
    logic        cnt_clr;
    logic        rx_rst;
    logic        wd_enable;
    logic [3:0]  rst_count;
    logic        locked_out;

    int total = 0;
    int bad   = 0;
    int n_hi;
    int n_wd0;

    always #5 clk = ~clk;

    rx_reset_sequencer #(
        .HOLD_WIDTH    (8),
        .HOLDOFF_WIDTH (16),
        .CNT_WIDTH     (4)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .enable        (enable),
        .wd_rst_req    (wd_rst_req),
        .power_trigger (power_trigger),
        .sig_valid     (sig_valid),
        .rst_hold_len  (rst_hold_len),
        .holdoff_len   (holdoff_len),
        .max_consec_th (max_consec_th),
        .cnt_clr       (cnt_clr),
        .rx_rst        (rx_rst),
        .wd_enable     (wd_enable),
        .rst_count     (rst_count),
        .locked_out    (locked_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One-cycle request followed by enough idle cycles to finish any hold+holdoff <= 9.
    task automatic pulse_req();
        wd_rst_req = 1'b1;
        tick();
        wd_rst_req = 1'b0;
        repeat (9) tick();
    endtask

    initial begin
        rstn = 1'b0; enable = 1'b0; wd_rst_req = 1'b0; power_trigger = 1'b0;
        sig_valid = 1'b0; rst_hold_len = 8'd4; holdoff_len = 16'd10;
        max_consec_th = 4'd0; cnt_clr = 1'b0;
        repeat (3) tick();
        chk("rst_rx_rst", rx_rst, 0);
        chk("rst_wd_en", wd_enable, 0);
        chk("rst_count", rst_count, 0);
        chk("rst_locked", locked_out, 0);
        rstn = 1'b1;
        enable = 1'b1;
        tick();
        chk("idle_wd_en", wd_enable, 1);

        // 1: hold 4, holdoff 10
        wd_rst_req = 1'b1;
        n_hi = 0; n_wd0 = 0;
        tick();
        chk("t1_latency", rx_rst, 1);
        wd_rst_req = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (rx_rst) n_hi++;
            if (!wd_enable) n_wd0++;
            tick();
        end
        chk("t1_rx_hi_cycles", n_hi, 4);
        chk("t1_wd_low_cycles", n_wd0, 14);
        chk("t1_count", rst_count, 1);

        // 2: hold 0 / holdoff 0, request held high
        rst_hold_len = 8'd0; holdoff_len = 16'd0;
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        chk("t2_clr", rst_count, 0);
        wd_rst_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("t2_rx_%0d", i), rx_rst, ((i % 2) == 0) ? 1 : 0);
        end
        wd_rst_req = 1'b0;
        tick();
        chk("t2_count", rst_count, 3);

        // 3: lockout after three resets without SIGNAL
        sig_valid = 1'b1; tick(); sig_valid = 1'b0;
        max_consec_th = 4'd3; rst_hold_len = 8'd2; holdoff_len = 16'd3;
        pulse_req();
        chk("t3_lock_after1", locked_out, 0);
        pulse_req();
        chk("t3_lock_after2", locked_out, 0);
        pulse_req();
        chk("t3_locked", locked_out, 1);
        chk("t3_lock_wd_en", wd_enable, 0);
        wd_rst_req = 1'b1;
        repeat (3) tick();
        chk("t3_req_ignored", rx_rst, 0);
        wd_rst_req = 1'b0;
        chk("t3_count", rst_count, 6);
        power_trigger = 1'b1;
        repeat (2) tick();
        chk("t3_still_locked", locked_out, 1);
        power_trigger = 1'b0;
        tick();
        chk("t3_released", locked_out, 0);
        chk("t3_release_wd_en", wd_enable, 1);

        // 4: SIGNAL between requests keeps consecutive count below threshold
        max_consec_th = 4'd2;
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pulse_req();
            chk($sformatf("t4_nolock_%0d", i), locked_out, 0);
            sig_valid = 1'b1; tick(); sig_valid = 1'b0;
        end
        chk("t4_count", rst_count, 5);

        // 5: enable dropped mid-reset
        max_consec_th = 4'd0; rst_hold_len = 8'd20; holdoff_len = 16'd10;
        wd_rst_req = 1'b1; tick(); wd_rst_req = 1'b0;
        repeat (3) tick();
        chk("t5_in_reset", rx_rst, 1);
        enable = 1'b0;
        tick();
        chk("t5_rx_dropped", rx_rst, 0);
        chk("t5_wd_off", wd_enable, 0);
        repeat (5) tick();
        chk("t5_rx_stays_low", rx_rst, 0);
        chk("t5_wd_stays_off", wd_enable, 0);
        enable = 1'b1;
        tick();
        chk("t5_wd_back", wd_enable, 1);
        chk("t5_no_rereset", rx_rst, 0);

        // 6: counter saturation, clear with simultaneous increment
        rst_hold_len = 8'd1; holdoff_len = 16'd0;
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        wd_rst_req = 1'b1;
        repeat (40) tick();
        wd_rst_req = 1'b0;
        repeat (2) tick();
        chk("t6_saturated", rst_count, 15);
        cnt_clr = 1'b1; wd_rst_req = 1'b1;
        tick();
        chk("t6_clr_and_inc", rst_count, 1);
        chk("t6_clr_inc_rx", rx_rst, 1);
        wd_rst_req = 1'b0;
        tick();
        cnt_clr = 1'b0;
        chk("t6_clr_alone", rst_count, 0);

        // Asynchronous reset in the middle of a reset pulse
        rst_hold_len = 8'd20;
        tick();
        wd_rst_req = 1'b1; tick(); wd_rst_req = 1'b0;
        tick();
        chk("ar_in_reset", rx_rst, 1);
        #2 rstn = 1'b0;
        #1;
        chk("ar_rx_async", rx_rst, 0);
        chk("ar_count", rst_count, 0);
        rstn = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
